wide_add_sequencer: RTL and testbench
=====================================

Name: wide_add_sequencer

Overview:
- Multi-cycle controller that performs a WORDS×32-bit add or subtract by sequencing the team's existing 32-bit combinational adder (a, b, c_in -> sum, c_out), one 32-bit word per cycle, LSW first, with carry chaining.
- The adder is instantiated beside this block at the parent level and is driven through the add_* ports.
- Valid/ready handshakes on the operand input and on the result output.

Parameters:
- WORDS, 4, number of 32-bit words per operand (legal: WORDS ≥ 2); operand width W = 32*WORDS.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept an operation
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_sub  input  1  0 = A+B, 1 = A−B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  W  result
- out_cout  output  1  final carry out (for subtract: 1 = no borrow)
- out_ovf  output  1  two's-complement signed overflow
- add_a  output  32  adder operand a
- add_b  output  32  adder operand b
- add_cin  output  1  adder carry in
- add_sum  input  32  adder sum (combinational from add_*)
- add_cout  input  1  adder carry out

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; idx, carry, and the operand and sum registers clear to 0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0; add_a/add_b/add_cin=0.
  - in_ready=0 while rst_n is low.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid & in_ready: latch a_reg=in_a, b_reg = in_sub ? ~in_b : in_b, carry=in_sub, idx=0, a_msb=in_a[W-1]; go to RUN.
  - in_* are sampled only at that edge.
- RUN:
  - in_ready=0.
  - Combinationally drive: add_a = a_reg word[idx], add_b = b_reg word[idx], add_cin = carry.
  - Each edge: out_sum word[idx] <= add_sum; carry <= add_cout; idx <= idx+1.
  - On the edge where idx==WORDS-1:
    - out_cout <= add_cout;
    - out_ovf <= (a_msb == b_reg[W-1]) & (add_sum[31] != a_msb);
    - go to DONE.
- DONE:
  - out_valid=1; in_ready=0; add_* driven to 0.
  - out_sum, out_cout and out_ovf are held stable.
  - On an edge with out_valid & out_ready: go to IDLE, out_valid=0 (registers are retained, not cleared).
- add_* outputs are 0 in IDLE and DONE.
- Latency: if the accept edge is edge 0, out_valid rises after edge WORDS.
- Throughput: at most one operation per WORDS+2 cycles; no back-to-back overlap (in_ready stays 0 in DONE even if out_ready=1).
- out_sum is valid only while out_valid=1; during RUN it holds partial and stale words.
- Arithmetic:
  - Result is modulo 2^W; the carry chains across words in LSW→MSW order.
  - Subtract is implemented as A + ~B + 1 (carry-in of word 0 = 1).
- Boundary conditions:
  - in_valid while busy (RUN/DONE): ignored, no effect.
  - out_ready high before out_valid: no effect.
  - in_valid and out_ready both high in DONE: only the output handshake occurs.
  - rst_n asserted mid-RUN or in DONE: operation aborted, no partial result is ever flagged valid. After release, the block is in IDLE with in_ready=1.
  - idx wraps only by leaving RUN; it never exceeds WORDS-1.

Test Plan:
- Reset and add_cin sequence (WORDS=4):
  - While rst_n is low: all outputs 0, in_ready=0. After release: in_ready=1, out_valid=0.
  - Add A=0x…0000_FFFF_FFFF, B=1, sub=0 -> out_sum=0x…0001_0000_0000, cout=0, ovf=0.
  - add_cin per RUN cycle = 0,1,0,0; out_valid exactly 4 edges after accept.
- Full wrap: A=all-ones (128b), B=1, sub=0 -> out_sum=0, out_cout=1, out_ovf=0.
- Subtract with borrow: A=5, B=7, sub=1 -> out_sum=0xFFFF…FFFE (−2), out_cout=0, out_ovf=0. add_b word0=0xFFFF_FFF8, add_cin word0=1.
- Signed overflow:
  - A=0x7FFF_FFFF_FFFF…FFFF, B=1, sub=0 -> out_sum=0x8000_0000_0…0, ovf=1, cout=0.
  - A=0x8000…0, B=1, sub=1 -> out_sum=0x7FFF…F, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid -> out_valid, out_sum and flags stable, in_ready=0, new operands not taken. Raise out_ready -> IDLE next cycle; next accept is earliest WORDS+2 cycles after the previous accept.
- Reset mid-operation: assert rst_n low asynchronously (between edges) during RUN with idx=2 -> outputs clear immediately, out_valid never rises. After release, 3+4 (sub=0) -> out_sum=7, cout=0, ovf=0.

Source files
------------

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_sequencer
// Brief    : WORDS x 32-bit add/subtract performed one word per cycle (LSW
//            first) through an external 32-bit combinational adder, with
//            valid/ready handshakes on operands and result.
// Revision : 1.0 - initial release
// ============================================================================
module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in_a,
  input  logic [32*WORDS-1:0]   in_b,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_cin,
  input  logic [31:0]           add_sum,
  input  logic                  add_cout
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] c_LAST = IDXW'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             r_state;
  logic [IDXW-1:0]        r_idx;
  logic                   r_carry;
  logic                   r_amsb;
  logic [WORDS-1:0][31:0] r_a;
  logic [WORDS-1:0][31:0] r_b;
  logic [WORDS-1:0][31:0] r_sum;
  logic                   r_cout;
  logic                   r_ovf;

  // Handshake flags; in_ready is gated by rst_n so it reads 0 during reset.
  assign in_ready  = rst_n & (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

  // Adder operands: current word pair plus chained carry in RUN, zero otherwise.
  always_comb begin
    add_a   = 32'd0;
    add_b   = 32'd0;
    add_cin = 1'b0;
    if (r_state == S_RUN) begin
      add_a   = r_a[r_idx];
      add_b   = r_b[r_idx];
      add_cin = r_carry;
    end
  end

  // Sequencer: latch operands, step through words collecting sums, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_amsb  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtract folds into A + ~B + 1: invert B here, carry-in 1.
            r_a     <= in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            r_carry <= in_sub;
            r_idx   <= '0;
            r_amsb  <= in_a[32*WORDS-1];
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[r_idx] <= add_sum;
          r_carry      <= add_cout;
          if (r_idx == c_LAST) begin
            r_cout  <= add_cout;
            // Signed overflow: same-sign operands (B after inversion) whose
            // result sign differs from A.
            r_ovf   <= (r_amsb == r_b[WORDS-1][31]) & (add_sum[31] != r_amsb);
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_add_sequencer
// Brief    : Self-checking bench for wide_add_sequencer: directed vector table,
//            randomized operations against an arithmetic reference model, and
//            hand-written backpressure / throughput / mid-run reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;
  localparam int WX    = W + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic          add_cin;
  logic [31:0]   add_sum;
  logic          add_cout;

  int checks   = 0;
  int failures = 0;

  // Capture from the most recent operation
  logic [3:0]  cin_tr;
  logic [31:0] b0;
  time         acc_t;

  always #5 clk = ~clk;

  // The parent-level 32-bit combinational adder
  assign {add_cout, add_sum} = 33'(add_a) + 33'(add_b) + 33'(add_cin);

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: whole-width arithmetic, borrow-free subtract gives cout=1.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W:0]   r;
    logic [W-1:0] s;
    logic         c;
    logic         o;
    if (sub) begin
      r = {1'b0, a} - {1'b0, b};
      c = (a >= b);
      o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r = {1'b0, a} + {1'b0, b};
      c = r[W];
      o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    s = r[W-1:0];
    return {o, c, s};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    logic [31:0]  w;
    r = '0;
    for (int i = 0; i < WORDS; i++) begin
      case ($urandom_range(0, 4))
        0:       w = 32'h0000_0000;
        1:       w = 32'hFFFF_FFFF;
        2:       w = 32'h7FFF_FFFF;
        3:       w = 32'h8000_0000;
        default: w = $urandom;
      endcase
      r[i*32 +: 32] = w;
    end
    return r;
  endfunction

  // One operation from the negedge: accept, wait for result, optionally hold
  // out_ready low for `hold` cycles while pulsing in_valid, then hand off.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int hold, output logic [W-1:0] s, output logic c,
                        output logic o, output int lat);
    int g;
    g = 0;
    while (in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout actual=%b required=1", in_ready);
    end
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0;
    lat = 0; cin_tr = '0; b0 = '0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (lat < 4) cin_tr[lat] = add_cin;
      if (lat == 0) b0 = add_b;
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) begin
      checks++; failures++;
      $display("FAIL out_valid_timeout actual=%b required=1", out_valid);
    end
    s = out_sum; c = out_cout; o = out_ovf;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_a = rnd_op(); in_b = rnd_op(); in_sub = i[0]; out_ready = 1'b0;
      @(negedge clk);
      chk("hold_out_valid", WX'(out_valid), WX'(1));
      chk("hold_in_ready", WX'(in_ready), WX'(0));
      chk("hold_sum", WX'(out_sum), WX'(s));
      chk("hold_flags", WX'({out_cout, out_ovf}), WX'({c, o}));
    end
    in_valid  = (hold > 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (hold > 0) begin
      chk("release_out_valid", WX'(out_valid), WX'(0));
      chk("release_in_ready", WX'(in_ready), WX'(1));
    end
  endtask

  initial begin
    vec_t         tbl[7];
    logic [W-1:0] s;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         c;
    logic         o;
    logic [W+1:0] m;
    int           lat;
    time          t1;
    logic         seen;

    tbl[0] = '{a: W'(64'h0000_0000_FFFF_FFFF), b: W'(1), sub: 1'b0,
               sum: W'(64'h0000_0001_0000_0000), cout: 1'b0, ovf: 1'b0};
    tbl[1] = '{a: {W{1'b1}}, b: W'(1), sub: 1'b0, sum: '0, cout: 1'b1, ovf: 1'b0};
    tbl[2] = '{a: W'(5), b: W'(7), sub: 1'b1, sum: {{(W-4){1'b1}}, 4'hE}, cout: 1'b0, ovf: 1'b0};
    tbl[3] = '{a: {1'b0, {(W-1){1'b1}}}, b: W'(1), sub: 1'b0,
               sum: {1'b1, {(W-1){1'b0}}}, cout: 1'b0, ovf: 1'b1};
    tbl[4] = '{a: {1'b1, {(W-1){1'b0}}}, b: W'(1), sub: 1'b1,
               sum: {1'b0, {(W-1){1'b1}}}, cout: 1'b1, ovf: 1'b1};
    tbl[5] = '{a: W'(3), b: W'(4), sub: 1'b0, sum: W'(7), cout: 1'b0, ovf: 1'b0};
    tbl[6] = '{a: '0, b: '0, sub: 1'b1, sum: '0, cout: 1'b1, ovf: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;

    // Reset state
    #23;
    chk("rst_in_ready", WX'(in_ready), WX'(0));
    chk("rst_out_valid", WX'(out_valid), WX'(0));
    chk("rst_out_sum", WX'(out_sum), WX'(0));
    chk("rst_flags", WX'({out_cout, out_ovf}), WX'(0));
    chk("rst_add_bus", WX'({add_a, add_b, add_cin}), WX'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", WX'(in_ready), WX'(1));
    chk("post_rst_out_valid", WX'(out_valid), WX'(0));

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, 0, s, c, o, lat);
      chk($sformatf("vec%0d_sum", i), WX'(s), WX'(tbl[i].sum));
      chk($sformatf("vec%0d_cout", i), WX'(c), WX'(tbl[i].cout));
      chk($sformatf("vec%0d_ovf", i), WX'(o), WX'(tbl[i].ovf));
      chk($sformatf("vec%0d_latency", i), WX'(lat), WX'(WORDS));
      if (i == 0) chk("vec0_cin_seq", WX'(cin_tr), WX'(4'b0010));
      if (i == 2) begin
        chk("sub_add_b_word0", WX'(b0), WX'(32'hFFFF_FFF8));
        chk("sub_add_cin_word0", WX'(cin_tr[0]), WX'(1));
      end
    end

    // Throughput: back-to-back operations accept WORDS+2 cycles apart
    run_op(W'(10), W'(20), 1'b0, 0, s, c, o, lat);
    t1 = acc_t;
    run_op(W'(30), W'(40), 1'b0, 0, s, c, o, lat);
    chk("throughput_gap", WX'((acc_t - t1) / 10), WX'(WORDS + 2));
    chk("throughput_sum", WX'(s), WX'(70));

    // Backpressure with in_valid pulsing in DONE
    ra = rnd_op(); rb = rnd_op();
    m = model(ra, rb, 1'b1);
    run_op(ra, rb, 1'b1, 10, s, c, o, lat);
    chk("bp_sum", WX'(s), WX'(m[W-1:0]));
    chk("bp_flags", WX'({c, o}), WX'({m[W], m[W+1]}));

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = rnd_op(); rb = rnd_op(); rs = 1'($urandom_range(0, 1));
      m = model(ra, rb, rs);
      run_op(ra, rb, rs, (i % 8 == 7) ? 2 : 0, s, c, o, lat);
      chk($sformatf("rnd%0d_sum", i), WX'(s), WX'(m[W-1:0]));
      chk($sformatf("rnd%0d_cout", i), WX'(c), WX'(m[W]));
      chk($sformatf("rnd%0d_ovf", i), WX'(o), WX'(m[W+1]));
    end

    // Asynchronous reset in RUN with idx=2
    @(negedge clk);
    ra = rnd_op() | {WORDS{32'h0000_0001}};
    rb = rnd_op() | {WORDS{32'h0000_0001}};
    in_a = ra; in_b = rb; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("midrun_add_a_word2", WX'(add_a), WX'(ra[64 +: 32]));
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", WX'(out_valid), WX'(0));
    chk("midrun_rst_in_ready", WX'(in_ready), WX'(0));
    chk("midrun_rst_out_sum", WX'(out_sum), WX'(0));
    chk("midrun_rst_add_bus", WX'({add_a, add_b, add_cin}), WX'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    #1;
    chk("midrun_release_in_ready", WX'(in_ready), WX'(1));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("midrun_no_valid", WX'(seen), WX'(0));
    run_op(W'(3), W'(4), 1'b0, 0, s, c, o, lat);
    chk("after_rst_sum", WX'(s), WX'(7));
    chk("after_rst_flags", WX'({c, o}), WX'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
